// File: rtl/isa_pkg.sv
// isa_pkg: shared definitions for the ISA bus master.
//   state_t    FSM state encoding (the WAIT state exists only with ISA_IOCHRDY_EN)
//   CTRL_*     bit positions inside control_in
//   FLOAT_BUS  value returned for a read that timed out on IOCHRDY
//   max2       helper used to size the shared phase counter
package isa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
`ifdef ISA_IOCHRDY_EN
      ST_WAIT,
`endif
      ST_HOLD
   } state_t;

   localparam int CTRL_READ = 0;
   localparam int CTRL_MEM  = 1;
   localparam int CTRL_WORD = 2;

   localparam logic [15:0] FLOAT_BUS = 16'hFFFF;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/isa_bus_master_timer.sv
// isa_phase_timer: loadable down-counter with zero flag, shared by every
// phase of the bus cycle (setup, strobe, hold and the IOCHRDY timeout).
//   i_clk       clock
//   i_rst_n     synchronous active-low reset
//   i_load      load i_load_val this edge (wins over counting)
//   i_load_val  cycles remaining minus one for the phase being entered
//   o_zero      high on the last cycle of the current phase
module isa_phase_timer #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/isa_bus_master.sv
// isa_bus_master: runs one ISA bus cycle per start pulse.
// Optional feature macro: ISA_IOCHRDY_EN (IOCHRDY wait states + timeout).
// Inputs : clk, reset (sync, active low), start, address_in, data_in,
//          control_in {word, mem, read}, sd_in, iochrdy
// Outputs: sa, sd_out, sd_oe, bale, ior_n, iow_n, memr_n, memw_n, sbhe_n,
//          busy, done, read_data, timeout
module isa_bus_master
   import isa_pkg::*;
#(
   parameter int SETUP_CYCLES   = 2,
   parameter int STROBE_CYCLES  = 8,
   parameter int HOLD_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] address_in,
   input  logic [15:0] data_in,
   input  logic [7:0]  control_in,
   input  logic [15:0] sd_in,
   input  logic        iochrdy,
   output logic [15:0] sa,
   output logic [15:0] sd_out,
   output logic        sd_oe,
   output logic        bale,
   output logic        ior_n,
   output logic        iow_n,
   output logic        memr_n,
   output logic        memw_n,
   output logic        sbhe_n,
   output logic        busy,
   output logic        done,
   output logic [15:0] read_data,
   output logic        timeout
);

   // Counter holds "cycles left minus one", so it must reach the largest count.
   localparam int MAXC = max2(max2(SETUP_CYCLES, STROBE_CYCLES),
                              max2(HOLD_CYCLES, TIMEOUT_CYCLES));
   localparam int TW   = $clog2(MAXC + 1);

   state_t        r_state, w_next;
   logic [15:0]   r_addr, r_data, r_read_data;
   logic [2:0]    r_ctrl;
   logic          r_bale, r_done;
   logic          w_load, w_zero, w_capture, w_accept;
   logic [TW-1:0] w_load_val;
   logic          w_rd, w_mem, w_word, w_strobe;
   logic          w_unused;

   assign w_unused = &{1'b0, iochrdy, control_in[7:3]};

`ifdef ISA_IOCHRDY_EN
   logic r_to, w_to_set;
`endif

   isa_phase_timer #(.W(TW)) u_timer (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_data      <= '0;
         r_ctrl      <= '0;
         r_bale      <= 1'b0;
         r_done      <= 1'b0;
         r_read_data <= '0;
`ifdef ISA_IOCHRDY_EN
         r_to        <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         r_bale  <= w_accept;
         r_done  <= (r_state == ST_HOLD) && w_zero;
         if (w_accept) begin
            r_addr <= address_in;
            // Byte cycles never drive the high data lane.
            r_data <= data_in & (control_in[CTRL_WORD] ? 16'hFFFF : 16'h00FF);
            r_ctrl <= control_in[2:0];
`ifdef ISA_IOCHRDY_EN
            r_to   <= 1'b0;
`endif
         end
         if (w_capture && w_rd)
            r_read_data <= w_word ? sd_in : {8'h00, sd_in[7:0]};
`ifdef ISA_IOCHRDY_EN
         if (w_to_set) begin
            r_to        <= 1'b1;
            r_read_data <= FLOAT_BUS;
         end
`endif
      end
   end

   assign w_accept = (r_state == ST_IDLE) && start;

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = '0;
      w_capture  = 1'b0;
`ifdef ISA_IOCHRDY_EN
      w_to_set   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: if (start) begin
            w_next     = ST_SETUP;
            w_load     = 1'b1;
            w_load_val = TW'(SETUP_CYCLES - 1);
         end
         ST_SETUP: if (w_zero) begin
            w_next     = ST_STROBE;
            w_load     = 1'b1;
            w_load_val = TW'(STROBE_CYCLES - 1);
         end
         ST_STROBE: if (w_zero) begin
`ifdef ISA_IOCHRDY_EN
            if (!iochrdy) begin
               w_next     = ST_WAIT;
               w_load     = 1'b1;
               w_load_val = TW'(TIMEOUT_CYCLES - 1);
            end else
`endif
            begin
               w_next     = ST_HOLD;
               w_load     = 1'b1;
               w_load_val = TW'(HOLD_CYCLES - 1);
               w_capture  = 1'b1;
            end
         end
`ifdef ISA_IOCHRDY_EN
         // Ready wins over a timeout expiring in the same cycle.
         ST_WAIT: if (iochrdy || w_zero) begin
            w_next     = ST_HOLD;
            w_load     = 1'b1;
            w_load_val = TW'(HOLD_CYCLES - 1);
            w_capture  = iochrdy;
            w_to_set   = !iochrdy;
         end
`endif
         ST_HOLD: if (w_zero) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_rd   = r_ctrl[CTRL_READ];
   assign w_mem  = r_ctrl[CTRL_MEM];
   assign w_word = r_ctrl[CTRL_WORD];
`ifdef ISA_IOCHRDY_EN
   assign w_strobe = (r_state == ST_STROBE) || (r_state == ST_WAIT);
   assign timeout  = r_to;
`else
   assign w_strobe = (r_state == ST_STROBE);
   assign timeout  = 1'b0;
`endif

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign bale      = r_bale;
   assign sa        = busy ? r_addr : '0;
   assign sbhe_n    = busy ? !w_word : 1'b1;
   assign sd_oe     = busy && !w_rd;
   assign sd_out    = sd_oe ? r_data : '0;
   assign ior_n     = !(w_strobe &&  w_rd && !w_mem);
   assign iow_n     = !(w_strobe && !w_rd && !w_mem);
   assign memr_n    = !(w_strobe &&  w_rd &&  w_mem);
   assign memw_n    = !(w_strobe && !w_rd &&  w_mem);
   assign read_data = r_read_data;

endmodule

// File: tb/tb_isa_bus_master.sv
module tb_isa_bus_master;
   localparam int S = 2, P = 8, H = 2, T = 16;

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, iochrdy = 1'b1;
   logic [15:0] address_in = '0, data_in = '0, sd_in = '0;
   logic [7:0]  control_in = '0;
   logic [15:0] sa, sd_out, read_data;
   logic        sd_oe, bale, ior_n, iow_n, memr_n, memw_n, sbhe_n, busy, done, timeout;

   int          checks = 0, errors = 0;
   logic [15:0] m_rd = '0;
   logic        m_to = 1'b0;

   always #5 clk = ~clk;

   isa_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H),
                    .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset), .start(start), .address_in(address_in),
      .data_in(data_in), .control_in(control_in), .sd_in(sd_in), .iochrdy(iochrdy),
      .sa(sa), .sd_out(sd_out), .sd_oe(sd_oe), .bale(bale), .ior_n(ior_n),
      .iow_n(iow_n), .memr_n(memr_n), .memw_n(memw_n), .sbhe_n(sbhe_n),
      .busy(busy), .done(done), .read_data(read_data), .timeout(timeout));

   logic [57:0] obs;
   assign obs = {sa, sd_out, sd_oe, bale, ior_n, iow_n, memr_n, memw_n,
                 sbhe_n, busy, done, timeout, read_data};

   // One bus cycle; called at a negedge with the DUT idle (or in its done cycle).
   // w = clocks iochrdy is held low starting at the last strobe cycle.
   // Cycle c is the clock period that ends at edge c (start sampled at edge 0).
   task automatic run_txn(input logic [15:0] a, input logic [15:0] d,
                          input logic [7:0] ct, input int w,
                          input logic [15:0] sd, input int pulse_c, input string name);
      logic        rd, mem, word, to, in_stb, after, be;
      logic [3:0]  stb;
      logic [15:0] dmask, new_rd;
      logic [57:0] exp;
      int          st, dc;
      rd = ct[0]; mem = ct[1]; word = ct[2];
`ifdef ISA_IOCHRDY_EN
      st = (w > T) ? T : w;
      to = (w > T);
`else
      st = 0;
      to = 1'b0;
`endif
      dc     = S + P + st + H + 1;
      dmask  = word ? 16'hFFFF : 16'h00FF;
      new_rd = to ? 16'hFFFF : (rd ? (sd & dmask) : m_rd);
      case ({mem, rd})      // {ior_n, iow_n, memr_n, memw_n}
         2'b01:   stb = 4'b0111;
         2'b00:   stb = 4'b1011;
         2'b11:   stb = 4'b1101;
         default: stb = 4'b1110;
      endcase
      address_in = a; data_in = d; control_in = ct; sd_in = sd; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= dc; c++) begin
         #1;
         start      = (c == pulse_c);
         iochrdy    = !(c >= S + P && c < S + P + w);
         address_in = 16'($urandom);
         data_in    = 16'($urandom);
         control_in = 8'($urandom);
         @(negedge clk);
         be     = (c < dc);
         in_stb = (c > S) && (c <= S + P + st);
         after  = (c > S + P + st);
         exp = {be ? a : 16'h0, (be && !rd) ? (d & dmask) : 16'h0, be && !rd,
                c == 1, in_stb ? stb : 4'hF, be ? !word : 1'b1, be, c == dc,
                after ? to : 1'b0, after ? new_rd : m_rd};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs, exp);
         end
         if (c < dc) @(posedge clk);
      end
      m_rd = new_rd; m_to = to; start = 1'b0; iochrdy = 1'b1;
   endtask

   task automatic idle(input int n, input string name);
      logic [57:0] exp;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 address_in = 16'($urandom);
         @(negedge clk);
         exp = {16'h0, 16'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, m_to, m_rd};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s idle %0d: got %h expected %h", name, i, obs, exp);
         end
      end
   endtask

   task automatic test_reset();
      logic [57:0] exp;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      exp = {16'h0, 16'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL reset_values: got %h expected %h", obs, exp);
      end
      reset = 1'b1; m_rd = '0; m_to = 1'b0;
      idle(2, "post_reset");
   endtask

   task automatic test_io_byte_write();
      run_txn(16'h0220, 16'h00A5, 8'h00, 0, 16'hDEAD, 0, "io_byte_write");
      idle(2, "io_byte_write");
   endtask

   task automatic test_mem_word_read();
      run_txn(16'hC000, 16'h5A5A, 8'h07, 0, 16'h1234, 0, "mem_word_read");
      idle(2, "mem_word_read");
   endtask

   task automatic test_iochrdy_wait();
      run_txn(16'h0300, 16'h0000, 8'h01, 5, 16'hAB77, 0, "iochrdy_wait5");
      idle(1, "iochrdy_wait5");
   endtask

   task automatic test_timeout();
      run_txn(16'h0310, 16'h0000, 8'h05, 40, 16'h4321, 0, "iochrdy_stuck");
      idle(2, "timeout_hold");
      run_txn(16'h0312, 16'h0000, 8'h05, 0, 16'h8765, 0, "timeout_clear");
      idle(1, "timeout_clear");
   endtask

   task automatic test_start_during_strobe();
      run_txn(16'hD000, 16'hBEEF, 8'h06, 0, 16'h0000, S + 3, "start_in_strobe");
      idle(3, "start_in_strobe");
   endtask

   task automatic test_back_to_back();
      run_txn(16'h1111, 16'hA1A1, 8'h04, 0, 16'h0F0F, 0, "b2b_0");
      run_txn(16'h2222, 16'hB2B2, 8'h03, 0, 16'hC3C3, 0, "b2b_1");
      run_txn(16'h3333, 16'hC4C4, 8'h01, 2, 16'hE5E5, 0, "b2b_2");
      idle(1, "b2b");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_txn(16'($urandom), 16'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
                 16'($urandom), 0, "random");
         if ($urandom_range(0, 1) == 1) idle(1, "random");
      end
      idle(1, "random");
   endtask

   task automatic test_reset_mid_strobe();
      logic [57:0] exp;
      address_in = 16'h0280; data_in = 16'h1357; control_in = 8'h04; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (iow_n !== 1'b0 || sd_oe !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_strobe_pre: iow_n=%b sd_oe=%b expected 0 1", iow_n, sd_oe);
      end
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      exp = {16'h0, 16'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0};
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL rst_mid_strobe: got %h expected %h", obs, exp);
      end
      reset = 1'b1; m_rd = '0; m_to = 1'b0;
      idle(2, "after_mid_reset");
   endtask

   initial begin
      test_reset();
      test_io_byte_write();
      test_mem_word_read();
      test_iochrdy_wait();
      test_timeout();
      test_start_during_strobe();
      test_back_to_back();
      test_random();
      test_reset_mid_strobe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
